// File: rtl/branch_history_table_pkg.sv
// Shared definitions for the per-PC branch history table: the 2-bit counter
// encoding, the counter reset state and the PC-to-index mapping.
package branch_history_table_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } cnt_state_e;

    localparam logic [1:0] CNT_RESET = STRONG_T;
    localparam int         STAT_W    = 16;

    // Word-aligned PC -> table index; entries is a power of two, so this is pc[IDX_W+1:2]
    function automatic int unsigned bht_idx(input logic [31:0] pc, input int unsigned entries);
        return (pc >> 32'd2) % entries;
    endfunction

endpackage

// File: rtl/branch_history_table_sat_counter2.sv
// Next-state logic of a 2-bit saturating direction counter: taken counts up,
// not-taken counts down, both saturate.
module sat_counter2
    import branch_history_table_pkg::*;
(
    input  logic [1:0] state,
    input  logic       taken,
    output logic [1:0] next_state
);

    // Saturating increment / decrement of the hysteresis counter
    always_comb begin
        next_state = state;
        case (state)
            STRONG_T:  next_state = taken ? STRONG_T : WEAK_T;
            WEAK_T:    next_state = taken ? STRONG_T : WEAK_NT;
            WEAK_NT:   next_state = taken ? WEAK_T   : STRONG_NT;
            STRONG_NT: next_state = taken ? WEAK_NT  : STRONG_NT;
            default:   next_state = CNT_RESET;
        endcase
    end

endmodule

// File: rtl/branch_history_table.sv
// Per-PC branch direction predictor: 2-bit counters looked up in ID, prediction
// carried to EX, trained on resolution. Optional statistics via BHT_STATS_EN.
module branch_history_table
    import branch_history_table_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
)
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              lookup_valid_i,
    input  logic [31:0]       lookup_pc_i,
    output logic              predict_o,
    input  logic              resolve_valid_i,
    input  logic              resolve_taken_i,
    output logic              mispredict_o,
    output logic              flush_o,
`ifdef BHT_STATS_EN
    output logic [STAT_W-1:0] branch_cnt_o,
    output logic [STAT_W-1:0] miss_cnt_o,
`endif
    output logic              inflight_v_o
);

    logic [1:0]       cnt_r [ENTRIES];
    logic             inflight_v_r;
    logic             inflight_pred_r;
    logic [IDX_W-1:0] inflight_idx_r;

    logic [IDX_W-1:0] lookup_idx_s;
    logic             predict_s;
    logic             update_s;
    logic             mispredict_s;
    logic [1:0]       cur_cnt_s;
    logic [1:0]       cnt_next_s;

    assign lookup_idx_s = IDX_W'(bht_idx(lookup_pc_i, ENTRIES));

    // Zero-latency prediction from the upper bit of the indexed counter
    always_comb begin
        predict_s = 1'b0;
        if (lookup_valid_i) begin
            predict_s = cnt_r[lookup_idx_s][1];
        end else begin
            predict_s = 1'b0;
        end
    end

    // A resolve only counts when a prediction was recorded for the branch in EX
    always_comb begin
        update_s     = resolve_valid_i & inflight_v_r;
        mispredict_s = 1'b0;
        if (update_s) begin
            mispredict_s = (resolve_taken_i != inflight_pred_r);
        end else begin
            mispredict_s = 1'b0;
        end
    end

    assign cur_cnt_s    = cnt_r[inflight_idx_r];
    assign predict_o    = predict_s;
    assign mispredict_o = mispredict_s;
    assign flush_o      = mispredict_s;
    assign inflight_v_o = inflight_v_r;

    // Single shared next-state block: only one counter is trained per cycle
    sat_counter2 u_sat_counter2 (
        .state      (cur_cnt_s),
        .taken      (resolve_taken_i),
        .next_state (cnt_next_s)
    );

    // Counter table training; reset drops any in-flight update
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_r[i] <= CNT_RESET;
            end
        end else if (update_s) begin
            cnt_r[inflight_idx_r] <= cnt_next_s;
        end
    end

    // In-flight record: captured each unstalled cycle, frozen while stalled
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_v_r    <= 1'b0;
            inflight_pred_r <= 1'b0;
            inflight_idx_r  <= '0;
        end else if (!stall_i) begin
            inflight_v_r    <= lookup_valid_i;
            inflight_pred_r <= predict_s;
            inflight_idx_r  <= lookup_idx_s;
        end
    end

`ifdef BHT_STATS_EN
    logic [STAT_W-1:0] branch_cnt_r;
    logic [STAT_W-1:0] miss_cnt_r;

    // Saturating resolve and mispredict statistics
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branch_cnt_r <= 16'd0;
            miss_cnt_r   <= 16'd0;
        end else begin
            if (update_s && (branch_cnt_r != 16'hFFFF)) begin
                branch_cnt_r <= branch_cnt_r + 16'd1;
            end
            if (mispredict_s && (miss_cnt_r != 16'hFFFF)) begin
                miss_cnt_r <= miss_cnt_r + 16'd1;
            end
        end
    end

    assign branch_cnt_o = branch_cnt_r;
    assign miss_cnt_o   = miss_cnt_r;
`endif

endmodule

// File: tb/tb_branch_history_table.sv
// Self-checking bench for branch_history_table: directed vector table, reset and
// statistics sequences, and randomized traffic against an array-based model.
module tb_branch_history_table;

    localparam int ENT = 16;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        lv;
    logic [31:0] pc;
    logic        rv;
    logic        rt;
    logic        predict;
    logic        mispredict;
    logic        flush;
    logic        inflight_v;
`ifdef BHT_STATS_EN
    logic [15:0] branch_cnt;
    logic [15:0] miss_cnt;
`endif

    branch_history_table #(.ENTRIES(ENT)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .stall_i         (stall),
        .lookup_valid_i  (lv),
        .lookup_pc_i     (pc),
        .predict_o       (predict),
        .resolve_valid_i (rv),
        .resolve_taken_i (rt),
        .mispredict_o    (mispredict),
        .flush_o         (flush),
`ifdef BHT_STATS_EN
        .branch_cnt_o    (branch_cnt),
        .miss_cnt_o      (miss_cnt),
`endif
        .inflight_v_o    (inflight_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: counter values as integers 0..3, plus the in-flight record
    int m_cnt [ENT];
    bit m_v;
    bit m_pred;
    int m_idx;
    int m_branches;
    int m_misses;

    typedef struct {
        bit          st;
        bit          lv;
        logic [31:0] pc;
        bit          rv;
        bit          rt;
        bit          ep;
        bit          em;
        bit          ei;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [31:0] p);
        return int'((p >> 2) % ENT);
    endfunction

    function automatic bit m_predict(input bit l, input logic [31:0] p);
        return l && (m_cnt[idx_of(p)] >= 2);
    endfunction

    function automatic bit m_mispredict(input bit r, input bit t);
        return r && m_v && (t != m_pred);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENT; i++) m_cnt[i] = 3;
        m_v = 1'b0; m_pred = 1'b0; m_idx = 0;
        m_branches = 0; m_misses = 0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_advance();
        bit p;
        p = m_predict(lv, pc);
        if (rv && m_v) begin
            if (m_branches < 65535) m_branches++;
            if (rt != m_pred && m_misses < 65535) m_misses++;
            if (rt) m_cnt[m_idx] = (m_cnt[m_idx] == 3) ? 3 : m_cnt[m_idx] + 1;
            else    m_cnt[m_idx] = (m_cnt[m_idx] == 0) ? 0 : m_cnt[m_idx] - 1;
        end
        if (!stall) begin
            m_v = lv; m_pred = p; m_idx = idx_of(pc);
        end
    endtask

    task automatic drive(input bit s, input bit l, input logic [31:0] p, input bit r, input bit t);
        stall = s; lv = l; pc = p; rv = r; rt = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle checked against the model, then clocked
    task automatic apply(input bit s, input bit l, input logic [31:0] p, input bit r, input bit t);
        bit em;
        drive(s, l, p, r, t);
        #3;
        em = m_mispredict(r, t);
        check("predict", predict, m_predict(l, p));
        check("mispredict", mispredict, em);
        check("flush", flush, em);
        check("inflight_v", inflight_v, m_v);
`ifdef BHT_STATS_EN
        check("branch_cnt", branch_cnt, m_branches);
        check("miss_cnt", miss_cnt, m_misses);
`endif
        model_advance();
        tick();
    endtask

    initial begin
        // st lv pc rv rt | predict mispredict inflight_v
        tbl.push_back('{1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'h04, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 32'h04, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 32'h44, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'h08, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 32'h08, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 32'h08, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 32'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 32'h08, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'h08, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 32'h08, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 32'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});

        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Post-reset state: nothing in flight, no flush, default prediction taken
        #3;
        check("rst_inflight_v", inflight_v, 1'b0);
        check("rst_mispredict", mispredict, 1'b0);
        check("rst_flush", flush, 1'b0);
        tick();

        // Directed table; the model shadows it so later phases stay aligned
        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].lv, tbl[i].pc, tbl[i].rv, tbl[i].rt);
            #3;
            check($sformatf("vec%0d_predict", i), predict, tbl[i].ep);
            check($sformatf("vec%0d_mispredict", i), mispredict, tbl[i].em);
            check($sformatf("vec%0d_flush", i), flush, tbl[i].em);
            check($sformatf("vec%0d_inflight_v", i), inflight_v, tbl[i].ei);
            model_advance();
            tick();
        end

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            apply($urandom_range(3, 0) == 0, $urandom_range(1, 0) == 1,
                  {$urandom_range(255, 0), 2'b00} ^ (32'($urandom) & 32'hFFFF_F003),
                  $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1);
        end

        // Reset with a branch in flight and a resolve pending
        apply(1'b0, 1'b1, 32'h10, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'h20, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        check("rst2_inflight_v", inflight_v, 1'b0);
        check("rst2_mispredict", mispredict, 1'b0);
        tick();
        for (int i = 0; i < ENT; i++) begin
            drive(1'b1, 1'b1, 32'(i * 4), 1'b0, 1'b0);
            #3;
            check($sformatf("rst2_predict_idx%0d", i), predict, 1'b1);
            tick();
        end

        // Five resolved branches with two mispredicts from a clean reset
        apply(1'b0, 1'b1, 32'h10, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 32'h10, 1'b1, 1'b1);
        apply(1'b0, 1'b1, 32'h10, 1'b1, 1'b0);
        apply(1'b0, 1'b1, 32'h10, 1'b1, 1'b1);
        apply(1'b0, 1'b1, 32'h10, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 32'h00, 1'b1, 1'b1);
`ifdef BHT_STATS_EN
        check("stats_branches", branch_cnt, 16'd5);
        check("stats_misses", miss_cnt, 16'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check("stats_rst_branches", branch_cnt, 16'd0);
        check("stats_rst_misses", miss_cnt, 16'd0);
`else
        check("seq_inflight_v_end", inflight_v, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_history_table.md
# branch_history_table

Per-PC branch direction predictor for the five-stage pipelined CPU, replacing the single shared 2-bit counter. Sits beside IF_ID/ID_EX: looks up a 2-bit saturating counter for the branch in ID, carries that prediction to EX, resolves it against the ALU outcome, and drives the IF_ID flush on a misprediction. All counters come out of reset strongly taken.

## Interface
- ENTRIES, 16: number of 2-bit counters; power of two, 2..256.
- IDX_W, $clog2(ENTRIES): index width; index = pc[IDX_W+1:2].
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- stall_i  in  1  pipeline stall; freezes the in-flight record; a lookup is ignored while high.
- lookup_valid_i  in  1  branch instruction decoded in ID this cycle.
- lookup_pc_i  in  32  PC of the branch in ID.
- predict_o  out  1  combinational: counter[idx(lookup_pc_i)][1]; 0 when lookup_valid_i=0.
- resolve_valid_i  in  1  branch in EX resolved this cycle (ID_EX Branch).
- resolve_taken_i  in  1  actual outcome (ALU zero for beq).
- mispredict_o  out  1  combinational: resolve_valid_i & inflight_v & (resolve_taken_i != inflight_pred).
- flush_o  out  1  equal to mispredict_o; drives IF_ID flush.
- inflight_v_o  out  1  registered: a prediction is held for the branch now in EX.

## Operation
- State: cnt[ENTRIES] (2 bits each), inflight_v, inflight_pred, inflight_idx.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Taken increments, not-taken decrements, saturating at 11/00.
- Per-counter FSM: 11 -T->11, 11 -NT->10, 10 -T->11, 10 -NT->01, 01 -T->10, 01 -NT->00, 00 -T->01, 00 -NT->00.
- Capture: on edge, if !stall_i: inflight_v <= lookup_valid_i; inflight_pred <= predict_o; inflight_idx <= idx(lookup_pc_i). If stall_i: record unchanged.
- Resolve: on edge, if resolve_valid_i & inflight_v: cnt[inflight_idx] updated by resolve_taken_i. resolve_valid_i without inflight_v: no update, mispredict_o=0.
- Resolution is independent of stall_i.
- Same-index lookup and update in one cycle: predict_o shows pre-update value; new value visible next cycle.
- rst_i: all cnt <= 11, inflight_v <= 0, inflight_pred <= 0, inflight_idx <= 0. Reset overrides simultaneous capture/update; mid-flight branch is dropped.

## Timing
- predict_o: 0-cycle (same cycle as lookup_valid_i).
- Lookup at cycle N -> inflight_v_o high N+1 -> resolve/mispredict_o in N+1 (no stall) -> counter updated at edge ending N+1, visible N+2.
- After reset: predict_o=1 for any PC, mispredict_o=0, flush_o=0, inflight_v_o=0.
- Back-to-back branches: record overwritten each unstalled cycle; resolving old record and capturing new one on the same edge is legal.

## Configuration
- BHT_STATS_EN defined: adds outputs branch_cnt_o[15:0] and miss_cnt_o[15:0], registered; branch_cnt_o increments on each counted resolve (resolve_valid_i & inflight_v), miss_cnt_o on each mispredict_o; both saturate at 16'hFFFF; reset to 0.
- Undefined: ports and counters absent; core behaviour identical.

## Structure
- Shared package: counter encoding constants (STRONG_NT, WEAK_NT, WEAK_T, STRONG_T), reset state STRONG_T, and IDX computation function.
- One sub-module: sat_counter2 (2-bit saturating counter next-state logic, pure function of current state and taken); instantiated per entry or as a shared function on the update path.

## Test plan
- Reset, lookup pc=0x10 -> predict_o=1; resolve taken -> mispredict_o=0, cnt[4] stays 11.
- Same PC resolved not-taken twice (cnt 11->10->01) -> third lookup predict_o=0; first not-taken resolve asserts mispredict_o and flush_o for one cycle.
- pc=0x04 and pc=0x44 (ENTRIES=16) alias to index 1: not-taken training via 0x04 changes prediction for 0x44.
- Lookup with stall_i=1 for 3 cycles -> inflight record unchanged, predict_o still combinationally valid, no capture.
- Lookup and resolve same index same cycle with cnt=10, not-taken -> predict_o=1 that cycle, 0 next cycle.
- rst_i asserted with inflight_v=1 and resolve_valid_i=1 -> no counter update, all entries 11, inflight_v_o=0; with BHT_STATS_EN, 5 branches/2 misses -> branch_cnt_o=5, miss_cnt_o=2, reset clears both.
